linked_list_fifo_drain: RTL and testbench

Downstream consumer for the shared-RAM multi-queue linked-list FIFO. It watches the per-queue count bus, picks a non-empty, enabled queue round-robin, and drives the FIFO's pop/pop_fifo. It absorbs the FIFO's one-cycle registered read latency into a small output buffer and presents {data, queue tag} on a valid/ready stream. Used to merge the multi-queue store into a single ordered stream toward the next pipeline stage.

---
 rtl/linked_list_fifo_drain.sv | 122 ++++++++++++
 tb/tb_linked_list_fifo_drain.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/linked_list_fifo_drain.sv
// Round-robin drain for the shared-RAM multi-queue FIFO: pops eligible queues under a credit
// limit, absorbs the one-cycle read latency and streams {data, queue tag} on valid/ready.
module linked_list_fifo_drain #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned FIFOS      = 8,
    parameter int unsigned LOG2_FIFOS = $clog2(FIFOS),
    parameter int unsigned LOG2_DEPTH = $clog2(DEPTH),
    parameter int unsigned OUT_DEPTH  = 4,
    parameter int unsigned LOG2_OUT   = $clog2(OUT_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LOG2_DEPTH*FIFOS-1:0]  count,
    input  logic [WIDTH-1:0]             fifo_q,
    input  logic [FIFOS-1:0]             enable,
    output logic                         pop,
    output logic [LOG2_FIFOS-1:0]        pop_fifo,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [LOG2_FIFOS-1:0]        out_fifo,
    output logic                         busy
);

    localparam int unsigned IDX_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW    = LOG2_OUT + 1;

    logic [LOG2_FIFOS-1:0] ptr_q;
    logic                  inflight_q;
    logic [LOG2_FIFOS-1:0] tag_q;
    logic [LOG2_OUT-1:0]   occ_q;
    logic [IDX_W-1:0]      head_q;
    logic [IDX_W-1:0]      tail_q;
    logic [WIDTH-1:0]      data_mem [OUT_DEPTH];
    logic [LOG2_FIFOS-1:0] tag_mem  [OUT_DEPTH];

    logic [FIFOS-1:0]      eligible;
    logic                  any_eligible;
    logic [LOG2_FIFOS-1:0] grant;
    logic [CW-1:0]         level;
    logic                  credit_ok;
    logic                  buf_wr;
    logic                  buf_rd;
    int unsigned           idx;

    always_comb begin
        eligible = '0;
        for (int unsigned g = 0; g < FIFOS; g++) begin
            eligible[g] = enable[g] && (count[g*LOG2_DEPTH +: LOG2_DEPTH] != '0);
        end
        any_eligible = |eligible;
    end

    // Scan starts just past the last grant so every eligible queue is served in turn.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int unsigned i = FIFOS; i >= 1; i--) begin
            idx = (32'(ptr_q) + i) % FIFOS;
            if (eligible[idx]) begin
                grant = LOG2_FIFOS'(idx);
            end
        end
    end

    // Credit counts the in-flight word so the buffer can never overflow.
    always_comb begin
        level     = CW'(occ_q) + CW'(inflight_q);
        credit_ok = level < CW'(OUT_DEPTH);
        pop       = !rst && credit_ok && any_eligible;
        pop_fifo  = grant;
    end

    assign out_valid = (occ_q != '0);
    assign out_data  = data_mem[head_q];
    assign out_fifo  = tag_mem[head_q];
    assign busy      = out_valid | inflight_q;
    assign buf_wr    = inflight_q;
    assign buf_rd    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= LOG2_FIFOS'(FIFOS - 1);
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= pop;
            if (pop) begin
                ptr_q <= grant;
                tag_q <= grant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            for (int unsigned e = 0; e < OUT_DEPTH; e++) begin
                data_mem[e] <= '0;
                tag_mem[e]  <= '0;
            end
        end else begin
            if (buf_wr) begin
                data_mem[tail_q] <= fifo_q;
                tag_mem[tail_q]  <= tag_q;
                tail_q <= (tail_q == IDX_W'(OUT_DEPTH - 1)) ? '0 : tail_q + 1'b1;
            end
            if (buf_rd) begin
                head_q <= (head_q == IDX_W'(OUT_DEPTH - 1)) ? '0 : head_q + 1'b1;
            end
            unique case ({buf_wr, buf_rd})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_linked_list_fifo_drain.sv
// Randomized bench: a queue-based FIFO environment feeds the drain; a grant-order scoreboard
// predicts pops and the output stream.
module tb_linked_list_fifo_drain;

    localparam int WIDTH = 8;
    localparam int FIFOS = 8;
    localparam int LD    = 5;
    localparam int LF    = 3;
    localparam int ODEP  = 4;
    localparam int NCYC  = 3000;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [LF-1:0]    f;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [LD*FIFOS-1:0] count;
    logic [WIDTH-1:0]  fifo_q;
    logic [FIFOS-1:0]  enable;
    logic              pop;
    logic [LF-1:0]     pop_fifo;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [LF-1:0]     out_fifo;
    logic              busy;

    linked_list_fifo_drain #(
        .WIDTH(WIDTH), .DEPTH(32), .FIFOS(FIFOS), .OUT_DEPTH(ODEP)
    ) dut (
        .clk(clk), .rst(rst), .count(count), .fifo_q(fifo_q), .enable(enable),
        .pop(pop), .pop_fifo(pop_fifo), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_fifo(out_fifo), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Environment and reference state.
    logic [WIDTH-1:0] fq [FIFOS][$];
    entry_t           exp_out [$];
    int               m_ptr;
    bit               m_inflight;
    logic [WIDTH-1:0] m_data;
    int               m_tag;
    bit               exp_pop;
    int               exp_sel;

    task automatic model_reset();
        for (int g = 0; g < FIFOS; g++) fq[g].delete();
        exp_out.delete();
        m_ptr      = FIFOS - 1;
        m_inflight = 0;
        m_data     = '0;
        m_tag      = 0;
    endtask

    task automatic drive_inputs(input int phase);
        logic [LD*FIFOS-1:0] cv;
        int pushes;
        int rdy_pct;
        pushes  = (phase == 3) ? 3 : ($urandom_range(99) < 60 ? 1 : 0);
        rdy_pct = (phase == 1) ? 20 : (phase == 3) ? 100 : (phase == 2) ? 70 : 90;
        for (int p = 0; p < pushes; p++) begin
            int q;
            q = (phase == 1) ? 1 : int'($urandom_range(FIFOS - 1));
            if (fq[q].size() < 31) fq[q].push_back(WIDTH'($urandom_range(255)));
        end
        cv = '0;
        for (int g = 0; g < FIFOS; g++) cv[g*LD +: LD] = LD'(fq[g].size());
        count     = cv;
        out_ready = ($urandom_range(99) < rdy_pct);
        if (phase == 2 || phase == 4) enable = FIFOS'($urandom_range(255));
        else enable = '1;
    endtask

    task automatic predict();
        exp_pop = 0;
        exp_sel = 0;
        if (exp_out.size() + int'(m_inflight) < ODEP) begin
            for (int i = 1; i <= FIFOS; i++) begin
                int g;
                g = (m_ptr + i) % FIFOS;
                if (!exp_pop && enable[g] && fq[g].size() != 0) begin
                    exp_pop = 1;
                    exp_sel = g;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("pop", 32'(pop), 32'(exp_pop));
        if (exp_pop && pop) check_eq("pop_fifo", 32'(pop_fifo), 32'(exp_sel));
        check_eq("out_valid", 32'(out_valid), 32'(exp_out.size() != 0));
        if (exp_out.size() != 0 && out_valid) begin
            check_eq("out_data", 32'(out_data), 32'(exp_out[0].d));
            check_eq("out_fifo", 32'(out_fifo), 32'(exp_out[0].f));
        end
        check_eq("busy", 32'(busy), 32'(exp_out.size() != 0 || m_inflight));
    endtask

    task automatic model_step();
        bit hs;
        hs = (exp_out.size() != 0) && out_ready;
        if (hs) void'(exp_out.pop_front());
        if (m_inflight) exp_out.push_back('{d: m_data, f: LF'(m_tag)});
        if (exp_pop) begin
            m_inflight = 1;
            m_tag      = exp_sel;
            m_data     = fq[exp_sel].pop_front();
            m_ptr      = exp_sel;
        end else begin
            m_inflight = 0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        count     = '0;
        fifo_q    = '0;
        enable    = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_eq("rst_pop", 32'(pop), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_fifo", 32'(out_fifo), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int phase;
            phase = cyc / 600;
            drive_inputs(phase);
            #1;
            predict();
            check_outputs();
            if (cyc > 50 && $urandom_range(99) < ((phase == 4) ? 3 : 1)) begin
                #2 rst = 1'b1;
                #1;
                check_eq("arst_valid", 32'(out_valid), 32'd0);
                check_eq("arst_busy", 32'(busy), 32'd0);
                check_eq("arst_pop", 32'(pop), 32'd0);
                model_reset();
                count = '0;
                @(posedge clk);
                #1 rst = 1'b0;
                fifo_q = '0;
                continue;
            end
            @(posedge clk);
            model_step();
            #1 fifo_q = m_data;
        end
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
